// File: rtl/z16_regfile_bp.sv
// Z16 general-purpose register file: two combinational read ports, one write port,
// optional hardwired zero register and write-to-read bypass, with a post-reset clear sequencer.
module z16_regfile_bp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_wen,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_ready
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [NREG];

  // Clear sequencer: one entry per cycle, ready after the last entry is zeroed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      o_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(NREG - 1)) begin
            state   <= READY;
            o_ready <= 1'b1;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // Array write: the clear owns the port until ready; user writes are dropped meanwhile.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (i_rd_wen) begin
        mem[i_rd_addr] <= i_rd_data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rdy,
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (!rdy) begin
      val = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && wen && (waddr == addr)) begin
      val = wdata;
    end
    return val;
  endfunction

  always_comb begin
    o_rs1_data = read_port(state == READY, i_rs1_addr, i_rd_wen, i_rd_addr, i_rd_data,
                           mem[i_rs1_addr]);
    o_rs2_data = read_port(state == READY, i_rs2_addr, i_rd_wen, i_rd_addr, i_rd_data,
                           mem[i_rs2_addr]);
  end

endmodule

// File: doc/z16_regfile_bp.md
# z16_regfile_bp

Parametrised general-purpose register file for the Z16 core: two combinational read ports, one synchronous write port, optional hardwired-zero register and optional write-to-read bypass. A synchronous reset starts a clear sequencer that zeroes every entry, one per cycle, and holds `o_ready` low until the array is fully clear. Sits between decode (read addresses) and writeback (rd port). Pipeline stall logic uses `o_ready` to hold issue after reset.

## Interface
- `DATA_W`, default 16: register width in bits.
- `ADDR_W`, default 4: address width; depth `NREG = 2**ADDR_W`.
- `ZERO_REG`, default 1: 1 makes address 0 always read 0. Writes to address 0 are still stored but never visible.
- `BYPASS`, default 1: 1 forwards same-cycle write data to matching read ports.

- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: synchronous, active-high reset; starts the clear sequence.
- `i_rs1_addr` in ADDR_W: read port 1 address.
- `i_rs2_addr` in ADDR_W: read port 2 address.
- `i_rd_addr` in ADDR_W: write address.
- `i_rd_wen` in 1: write enable.
- `i_rd_data` in DATA_W: write data.
- `o_rs1_data` out DATA_W: read port 1 data, combinational.
- `o_rs2_data` out DATA_W: read port 2 data, combinational.
- `o_ready` out 1: 1 when the clear sequence is done and the array is usable.

## Operation
- **Storage:** `NREG` x `DATA_W` array plus the clear FSM. The FSM has a state bit and an ADDR_W-bit counter `clr_cnt`.
- **FSM states:**
  - `CLEAR`: each edge writes 0 to `mem[clr_cnt]`, then `clr_cnt <= clr_cnt + 1`. On the edge that clears entry `NREG-1`, go to `READY`.
  - `READY`: normal operation. Stays here until `i_rst`.
- **Reset:**
  - `i_rst=1` at any edge, in any state: state becomes `CLEAR`, `clr_cnt` becomes 0, `o_ready` becomes 0.
  - Reset has priority over the clear write and over any user write on that edge.
  - Reset in the middle of a clear restarts the count at 0.
- **Write in `READY`:** if `i_rd_wen=1`, `mem[i_rd_addr] <= i_rd_data` at the edge. Otherwise the entry is unchanged.
- **Write in `CLEAR`:** `i_rd_wen` is ignored and the write is dropped. Upstream must not write before `o_ready`.
- **Read, applied per port in this priority order:**
  1. Not `READY`: output 0.
  2. `ZERO_REG=1` and address 0: output 0.
  3. `BYPASS=1`, `i_rd_wen=1`, and `i_rd_addr` equals the read address: output `i_rd_data`.
  4. Otherwise: output `mem[addr]`.
- Both read ports may use the same address; each resolves independently.
- **Width rules:** no arithmetic on data. `clr_cnt` wraps naturally at `NREG`, but the FSM leaves `CLEAR` at that point, so the wrap is never observed.

## Timing
- **Reset values:** `o_ready=0`. `o_rs1_data` and `o_rs2_data` are 0 while `o_ready=0`.
- **Clear latency:** if `i_rst` is sampled high at edge k and low afterwards, entries 0..NREG-1 are cleared at edges k+1..k+NREG. `o_ready` rises right after edge k+NREG (16 cycles for defaults).
- **Write latency:** data written at edge t reads back from the array from cycle t+1.
- **Bypass:** with `BYPASS=1` the written data is also visible combinationally in cycle t, before the edge. With `BYPASS=0`, reads in cycle t return the old value.
- **Paths:** read path is combinational, address to data, with no registered output. The write path is a single edge.
- **Reset held:** no clearing progresses while `i_rst` is held high. `clr_cnt` stays 0.

## Test plan
- **Reset clear:** preload reg5=0xBEEF (`BYPASS=1`, `ZERO_REG=1`), pulse `i_rst` for 1 cycle.
  - `o_ready=0` for exactly 16 cycles, then 1.
  - Reading rs1=5 returns 0 during and after the clear.
- **Write then read:** after ready, write reg3=0x1234 at edge t.
  - Cycle t: rs1=3 reads 0x1234 via bypass.
  - Cycle t+1: rs2=3 reads 0x1234 from the array.
  - Repeat with `BYPASS=0`: cycle t reads the old value 0.
- **Zero register:** write reg0=0xFFFF with `ZERO_REG=1`. rs1=0 and rs2=0 read 0 in the write cycle and afterwards.
- **Write during clear:** assert `i_rd_wen`, reg7=0xAAAA, at clear cycle 3.
  - After ready, reg7 reads 0.
  - `o_ready` timing is unchanged.
- **Reset mid-clear:** re-assert `i_rst` at clear cycle 10. `o_ready` rises exactly 16 cycles after the second reset edge.
- **Parameter sweep:** run `DATA_W=32`, `ADDR_W=5`.
  - Clear takes 32 cycles.
  - Write and read back 0xDEADBEEF at reg31 on both ports at once.
